// File: rtl/param_register_file_if.sv
// Bus bundle between the decode/writeback logic and the register file.
// The master drives write, read-address and mark strobes; the slave (the
// register file) returns read data, busy status and the registered flags.
interface param_register_file_if #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_WIDTH  = 2
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                   write_reg_en;
  logic [ADDR_WIDTH-1:0]  write_reg;
  logic [WORD_LENGTH-1:0] write_data;
  logic                   carry_in;
  logic                   flags_en;
  logic [ADDR_WIDTH-1:0]  read_reg1;
  logic [ADDR_WIDTH-1:0]  read_reg2;
  logic [WORD_LENGTH-1:0] read_data1;
  logic [WORD_LENGTH-1:0] read_data2;
  logic                   mark_en;
  logic [ADDR_WIDTH-1:0]  mark_reg;
  logic                   busy1;
  logic                   busy2;
  logic [DEPTH-1:0]       busy_vec;
  logic [2:0]             CZN_from_RF;

  modport master (
    output write_reg_en, write_reg, write_data, carry_in, flags_en,
    output read_reg1, read_reg2, mark_en, mark_reg,
    input  read_data1, read_data2, busy1, busy2, busy_vec, CZN_from_RF
  );

  modport slave (
    input  write_reg_en, write_reg, write_data, carry_in, flags_en,
    input  read_reg1, read_reg2, mark_en, mark_reg,
    output read_data1, read_data2, busy1, busy2, busy_vec, CZN_from_RF
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports with optional same-cycle write forwarding, registered C/Z/N
// flags and a per-register busy scoreboard for stalling on pending writes.
module param_register_file #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_WIDTH  = 2,
  parameter int BYPASS      = 1
) (
  input logic                clk,
  input logic                rst,
  param_register_file_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_LENGTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]       r_busy;
  logic [2:0]             r_czn;

  logic [DEPTH-1:0]       w_busyNext;
  logic                   w_hit1;
  logic                   w_hit2;
  logic                   w_markHit1;
  logic                   w_markHit2;
  logic                   w_flagZ;
  logic                   w_flagN;

  // Register array: only the addressed entry changes on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (rf.write_reg_en) begin
      r_regs[rf.write_reg] <= rf.write_data;
    end
  end

  // Flag values derived from the word being written this cycle.
  always_comb begin
    w_flagZ = (rf.write_data == '0);
    w_flagN = rf.write_data[WORD_LENGTH-1];
  end

  // Flags only move when a write carries flags_en; they are never forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_czn <= 3'b000;
    end else if (rf.write_reg_en && rf.flags_en) begin
      r_czn <= {w_flagN, w_flagZ, rf.carry_in};
    end
  end

  // Next scoreboard: clear on write first, then set on mark so a new producer wins.
  always_comb begin
    w_busyNext = r_busy;
    if (rf.write_reg_en) begin
      w_busyNext[rf.write_reg] = 1'b0;
    end
    if (rf.mark_en) begin
      w_busyNext[rf.mark_reg] = 1'b1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  // Forwarding hits: a write to the read address this cycle, when bypass is built in.
  always_comb begin
    w_hit1     = (BYPASS != 0) && rf.write_reg_en && (rf.write_reg == rf.read_reg1);
    w_hit2     = (BYPASS != 0) && rf.write_reg_en && (rf.write_reg == rf.read_reg2);
    w_markHit1 = rf.mark_en && (rf.mark_reg == rf.read_reg1);
    w_markHit2 = rf.mark_en && (rf.mark_reg == rf.read_reg2);
  end

  // Read ports and busy status; a forwarded write hides busy unless re-marked this cycle.
  always_comb begin
    rf.read_data1 = w_hit1 ? rf.write_data : r_regs[rf.read_reg1];
    rf.read_data2 = w_hit2 ? rf.write_data : r_regs[rf.read_reg2];
    rf.busy1      = (w_hit1 && !w_markHit1) ? 1'b0 : r_busy[rf.read_reg1];
    rf.busy2      = (w_hit2 && !w_markHit2) ? 1'b0 : r_busy[rf.read_reg2];
    rf.busy_vec    = r_busy;
    rf.CZN_from_RF = r_czn;
  end
endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file: a table of per-cycle vectors
// for the default bypassing 8x4 build, plus short hand sequences for reset
// dominance, a non-bypassing build and a 16-bit x 8 build.
module tb_param_register_file;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // One cycle of stimulus for the 8-bit bypass build and the outputs expected in that cycle.
  typedef struct {
    logic       we;
    logic [1:0] wreg;
    logic [7:0] wdata;
    logic       carry;
    logic       fen;
    logic [1:0] rr1;
    logic [1:0] rr2;
    logic       men;
    logic [1:0] mreg;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       b1;
    logic       b2;
    logic [3:0] bv;
    logic [2:0] czn;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];

  param_register_file_if #(.WORD_LENGTH(8),  .ADDR_WIDTH(2)) ifA ();
  param_register_file_if #(.WORD_LENGTH(8),  .ADDR_WIDTH(2)) ifN ();
  param_register_file_if #(.WORD_LENGTH(16), .ADDR_WIDTH(3)) ifW ();

  param_register_file #(.WORD_LENGTH(8), .ADDR_WIDTH(2), .BYPASS(1)) dutA (
    .clk(clk), .rst(rst), .rf(ifA)
  );
  param_register_file #(.WORD_LENGTH(8), .ADDR_WIDTH(2), .BYPASS(0)) dutN (
    .clk(clk), .rst(rst), .rf(ifN)
  );
  param_register_file #(.WORD_LENGTH(16), .ADDR_WIDTH(3), .BYPASS(1)) dutW (
    .clk(clk), .rst(rst), .rf(ifW)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic we, input logic [1:0] wreg, input logic [7:0] wdata,
    input logic carry, input logic fen, input logic [1:0] rr1, input logic [1:0] rr2,
    input logic men, input logic [1:0] mreg, input logic [7:0] rd1, input logic [7:0] rd2,
    input logic b1, input logic b2, input logic [3:0] bv, input logic [2:0] czn);
    vec_t v;
    v.we = we; v.wreg = wreg; v.wdata = wdata; v.carry = carry; v.fen = fen;
    v.rr1 = rr1; v.rr2 = rr2; v.men = men; v.mreg = mreg;
    v.rd1 = rd1; v.rd2 = rd2; v.b1 = b1; v.b2 = b2; v.bv = bv; v.czn = czn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic idleAll();
    ifA.write_reg_en = 0; ifA.write_reg = '0; ifA.write_data = '0; ifA.carry_in = 0;
    ifA.flags_en = 0; ifA.read_reg1 = '0; ifA.read_reg2 = '0; ifA.mark_en = 0; ifA.mark_reg = '0;
    ifN.write_reg_en = 0; ifN.write_reg = '0; ifN.write_data = '0; ifN.carry_in = 0;
    ifN.flags_en = 0; ifN.read_reg1 = '0; ifN.read_reg2 = '0; ifN.mark_en = 0; ifN.mark_reg = '0;
    ifW.write_reg_en = 0; ifW.write_reg = '0; ifW.write_data = '0; ifW.carry_in = 0;
    ifW.flags_en = 0; ifW.read_reg1 = '0; ifW.read_reg2 = '0; ifW.mark_en = 0; ifW.mark_reg = '0;
  endtask

  // Drive one vector just after the rising edge and queue its expected outputs.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    ifA.write_reg_en = v.we;  ifA.write_reg = v.wreg; ifA.write_data = v.wdata;
    ifA.carry_in     = v.carry; ifA.flags_en = v.fen;
    ifA.read_reg1    = v.rr1; ifA.read_reg2 = v.rr2;
    ifA.mark_en      = v.men; ifA.mark_reg  = v.mreg;
    expQ.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with the DUT on the falling edge.
  task automatic checkQueued(input int idx);
    vec_t e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput($sformatf("v%0d.queue", idx), 32'(0), 32'(1));
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("v%0d.rd1", idx), 32'(ifA.read_data1),  32'(e.rd1));
      checkOutput($sformatf("v%0d.rd2", idx), 32'(ifA.read_data2),  32'(e.rd2));
      checkOutput($sformatf("v%0d.b1",  idx), 32'(ifA.busy1),       32'(e.b1));
      checkOutput($sformatf("v%0d.b2",  idx), 32'(ifA.busy2),       32'(e.b2));
      checkOutput($sformatf("v%0d.bv",  idx), 32'(ifA.busy_vec),    32'(e.bv));
      checkOutput($sformatf("v%0d.czn", idx), 32'(ifA.CZN_from_RF), 32'(e.czn));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idleAll();

    //            we wr wdata  c  fe r1 r2 me mr  rd1    rd2    b1 b2 bv       czn
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 0, 3, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 2, 1, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(1, 1, 8'hA5, 1, 0, 0, 2, 0, 0, 8'h00, 8'h00, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(1, 3, 8'h3C, 0, 0, 1, 2, 0, 0, 8'hA5, 8'h00, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 1, 3, 0, 0, 8'hA5, 8'h3C, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(1, 0, 8'h77, 0, 0, 0, 0, 0, 0, 8'h77, 8'h77, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h77, 8'hA5, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(1, 2, 8'h00, 1, 1, 2, 3, 0, 0, 8'h00, 8'h3C, 0, 0, 4'b0000, 3'b000));
    vecs.push_back(mkVec(1, 2, 8'h80, 0, 1, 2, 0, 0, 0, 8'h80, 8'h77, 0, 0, 4'b0000, 3'b011));
    vecs.push_back(mkVec(1, 1, 8'h12, 1, 0, 1, 2, 0, 0, 8'h12, 8'h80, 0, 0, 4'b0000, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 8'h12, 8'h12, 0, 0, 4'b0000, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 3, 2, 0, 0, 8'h3C, 8'h80, 0, 0, 4'b0000, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 2, 3, 1, 2, 8'h80, 8'h3C, 0, 0, 4'b0000, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 2, 1, 0, 0, 8'h80, 8'h12, 1, 0, 4'b0100, 3'b100));
    vecs.push_back(mkVec(1, 1, 8'h34, 0, 0, 2, 1, 1, 2, 8'h80, 8'h34, 1, 0, 4'b0100, 3'b100));
    vecs.push_back(mkVec(1, 2, 8'h55, 0, 0, 2, 2, 0, 0, 8'h55, 8'h55, 0, 0, 4'b0100, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 2, 0, 0, 0, 8'h55, 8'h77, 0, 0, 4'b0000, 3'b100));
    vecs.push_back(mkVec(1, 2, 8'h66, 0, 0, 2, 2, 1, 2, 8'h66, 8'h66, 0, 0, 4'b0000, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 2, 3, 1, 3, 8'h66, 8'h3C, 1, 0, 4'b0100, 3'b100));
    vecs.push_back(mkVec(1, 2, 8'h01, 0, 0, 2, 3, 1, 0, 8'h01, 8'h3C, 0, 1, 4'b1100, 3'b100));
    vecs.push_back(mkVec(1, 3, 8'hFF, 1, 1, 3, 0, 1, 3, 8'hFF, 8'h77, 1, 1, 4'b1001, 3'b100));
    vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 3, 2, 0, 0, 8'hFF, 8'h01, 1, 0, 4'b1001, 3'b101));

    // Two reset cycles; the second also tries to write, mark and update flags.
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifA.write_reg_en = 1; ifA.write_reg = 2'd2; ifA.write_data = 8'h5A;
    ifA.flags_en = 1; ifA.carry_in = 1; ifA.mark_en = 1; ifA.mark_reg = 2'd1;
    @(posedge clk); #1;
    rst = 1'b0;
    idleAll();

    // Table-driven vectors on the bypassing 8-bit build.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkQueued(i);
    end

    // Reset dominates a simultaneous write, mark and flag update.
    @(posedge clk); #1;
    rst = 1'b1;
    ifA.write_reg_en = 1; ifA.write_reg = 2'd1; ifA.write_data = 8'hAA;
    ifA.flags_en = 1; ifA.carry_in = 1; ifA.mark_en = 1; ifA.mark_reg = 2'd2;
    @(posedge clk); #1;
    rst = 1'b0;
    idleAll();
    ifA.read_reg1 = 2'd1; ifA.read_reg2 = 2'd3;
    @(negedge clk);
    checkOutput("rst.rd1", 32'(ifA.read_data1),  32'(8'h00));
    checkOutput("rst.rd2", 32'(ifA.read_data2),  32'(8'h00));
    checkOutput("rst.bv",  32'(ifA.busy_vec),    32'(4'b0000));
    checkOutput("rst.czn", 32'(ifA.CZN_from_RF), 32'(3'b000));
    checkOutput("rst.b1",  32'(ifA.busy1),       32'(1'b0));

    // Non-bypassing build: writes and busy clears show only after the edge.
    @(posedge clk); #1;
    ifN.write_reg_en = 1; ifN.write_reg = 2'd0; ifN.write_data = 8'h77; ifN.read_reg1 = 2'd0;
    @(negedge clk);
    checkOutput("nb.rd1_same", 32'(ifN.read_data1), 32'(8'h00));
    @(posedge clk); #1;
    ifN.write_reg_en = 0; ifN.mark_en = 1; ifN.mark_reg = 2'd1;
    @(negedge clk);
    checkOutput("nb.rd1_next", 32'(ifN.read_data1), 32'(8'h77));
    @(posedge clk); #1;
    ifN.mark_en = 0; ifN.write_reg_en = 1; ifN.write_reg = 2'd1; ifN.write_data = 8'h11;
    ifN.read_reg1 = 2'd1;
    @(negedge clk);
    checkOutput("nb.b1_same",  32'(ifN.busy1),      32'(1'b1));
    checkOutput("nb.rd1_old",  32'(ifN.read_data1), 32'(8'h00));
    @(posedge clk); #1;
    ifN.write_reg_en = 0;
    @(negedge clk);
    checkOutput("nb.b1_next",  32'(ifN.busy1),      32'(1'b0));
    checkOutput("nb.rd1_new",  32'(ifN.read_data1), 32'(8'h11));
    checkOutput("nb.bv",       32'(ifN.busy_vec),   32'(4'b0000));

    // Wide build: 16-bit words, eight registers, sign flag from bit 15.
    @(posedge clk); #1;
    ifW.write_reg_en = 1; ifW.write_reg = 3'd7; ifW.write_data = 16'h8000;
    ifW.flags_en = 1; ifW.carry_in = 0; ifW.read_reg1 = 3'd7;
    ifW.mark_en = 1; ifW.mark_reg = 3'd5;
    @(negedge clk);
    checkOutput("w.rd1_byp", 32'(ifW.read_data1),  32'(16'h8000));
    checkOutput("w.czn_old", 32'(ifW.CZN_from_RF), 32'(3'b000));
    @(posedge clk); #1;
    ifW.write_reg_en = 0; ifW.flags_en = 0; ifW.mark_en = 0; ifW.read_reg2 = 3'd5;
    @(negedge clk);
    checkOutput("w.rd1",  32'(ifW.read_data1),  32'(16'h8000));
    checkOutput("w.czn",  32'(ifW.CZN_from_RF), 32'(3'b100));
    checkOutput("w.bv",   32'(ifW.busy_vec),    32'(8'h20));
    checkOutput("w.b2",   32'(ifW.busy2),       32'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the datapath: the successor to the fixed 4×8 accumulator bank. One synchronous write port, two asynchronous read ports, optional write-to-read bypass, registered CZN flags, and a per-register busy scoreboard that lets the controller stall on pending writes. It sits between the decode stage (read/mark addresses) and the ALU/writeback path (write data and carry).

## Interface
- WORD_LENGTH, 8, data width in bits (≥2)
- ADDR_WIDTH, 2, register address width; DEPTH = 2**ADDR_WIDTH registers
- BYPASS, 1, 1: same-cycle write is forwarded to read ports and busy outputs; 0: no forwarding

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- write_reg_en  in  1  write strobe
- write_reg  in  ADDR_WIDTH  write address
- write_data  in  WORD_LENGTH  write data
- carry_in  in  1  ALU carry accompanying write_data
- flags_en  in  1  update CZN flags with this write (ignored when write_reg_en=0)
- read_reg1, read_reg2  in  ADDR_WIDTH  read addresses
- read_data1, read_data2  out  WORD_LENGTH  read data (combinational)
- mark_en  in  1  mark a register busy (pending producer issued)
- mark_reg  in  ADDR_WIDTH  register to mark
- busy1, busy2  out  1  busy status of read_reg1 / read_reg2 (combinational)
- busy_vec  out  DEPTH  raw scoreboard, bit i = register i busy
- CZN_from_RF  out  3  registered flags: [0]=C, [1]=Z, [2]=N

## Operation
- Storage: DEPTH × WORD_LENGTH register array; on edge with write_reg_en=1, reg[write_reg] ← write_data. No other register changes.
- Reads: read_dataN = reg[read_regN]. If BYPASS=1, write_reg_en=1 and write_reg==read_regN, read_dataN = write_data instead. Both ports may address the same register.
- Flags: on edge with write_reg_en=1 and flags_en=1: C ← carry_in, Z ← (write_data==0), N ← write_data[WORD_LENGTH-1] (two's-complement sign). Otherwise flags hold.
- Scoreboard: busy[mark_reg] set on edge when mark_en=1; busy[write_reg] cleared on edge when write_reg_en=1. Same register marked and written in same cycle: mark wins (bit ends set; new producer supersedes). Different registers: both take effect.
- busyN = busy[read_regN]; if BYPASS=1 and write_reg_en=1 and write_reg==read_regN, busyN = 0 (data being forwarded), unless mark_en=1 with mark_reg==read_regN in the same cycle, in which case busyN = busy[read_regN] (current stored value).
- busy_vec reflects stored bits only, never bypassed.
- Writing a non-busy register is legal; clears nothing extra.
- Marking an already-busy register is legal; stays set.

## Timing
- Reset (rst=1 at edge): all registers 0, CZN_from_RF=3'b000, busy_vec=0. Reset dominates write, mark and flag update in the same cycle. Outputs after reset: read_data1/2=0 (unless bypassing), busy1/2=0.
- Write latency: 1 cycle to array (visible on read ports the cycle after the edge); 0 cycles with BYPASS=1.
- Flag latency: 1 cycle; CZN_from_RF never combinationally depends on write_data.
- Mark latency: busy visible from cycle after mark_en.
- No handshake; every strobe is accepted in the cycle it is asserted.
- Out-of-range addresses impossible by construction (DEPTH = 2**ADDR_WIDTH).

## Test plan
- Reset then idle: rst=1 one cycle -> all read_data=0, CZN=000, busy_vec=0; write r2=8'h5A same cycle as rst -> r2 still 0 after reset.
- Write/read: write r1=8'hA5, r3=8'h3C on consecutive cycles, flags_en=0 -> next cycles read_data1(r1)=A5, read_data2(r3)=3C, CZN unchanged.
- Bypass: BYPASS=1, write r0=8'h77 while read_reg1=0 -> read_data1=77 same cycle; BYPASS=0 build -> read_data1=old value, 77 next cycle.
- Flags: write 8'h00, carry_in=1, flags_en=1 -> CZN=3'b011; write 8'h80, carry_in=0 -> CZN=3'b100; write 8'h12 with flags_en=0 -> CZN stays 100.
- Scoreboard: mark r2 -> busy_vec=4'b0100, busy1=1 for read_reg1=2; write r2 (BYPASS=1) -> busy1=0 that cycle, busy_vec=0 next; mark and write r2 same cycle -> busy_vec[2]=1 after edge.
- Parametrisation: WORD_LENGTH=16, ADDR_WIDTH=3 -> write r7=16'h8000 with flags_en -> read r7=8000, N=1, Z=0; busy_vec width 8.
